knn_topk_stream_sort: RTL and testbench

Streaming top-K distance sorter for the KNN datapath. It accepts one (distance, type) candidate per cycle over a valid/ready handshake. It keeps the K smallest distances of each frame in an insertion-sorted register array and presents them as one sorted result when the frame's last element arrives. It replaces the fixed-N combinational odd-even network: frame length is now variable and unbounded, and only K slots of storage are required.

---
 rtl/knn_topk_stream_sort.sv | 121 ++++++++++++
 tb/tb_knn_topk_stream_sort.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_topk_stream_sort.sv
// Streaming top-K distance sorter: keeps the K smallest (distance, type)
// pairs of a frame in an insertion-sorted register array.
module knn_topk_stream_sort #(
    parameter int W      = 16,
    parameter int TYPE_W = 4,
    parameter int K      = 4,
    parameter int MAX_N  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_distance,
    input  logic [TYPE_W-1:0]   in_type,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [K*W-1:0]      out_distance,
    output logic [K*TYPE_W-1:0] out_type,
    output logic [$clog2(K+1)-1:0] out_count,
    output logic                out_overflow
);

    localparam int CW = $clog2(K + 1);
    localparam int NW = $clog2(MAX_N + 2);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t state, state_nxt;

    logic [W-1:0]      slot_d [K];
    logic [TYPE_W-1:0] slot_t [K];
    logic [W-1:0]      nxt_d  [K];
    logic [TYPE_W-1:0] nxt_t  [K];
    logic [W-1:0]      sh_d   [K];
    logic [TYPE_W-1:0] sh_t   [K];
    logic [K-1:0]      le;
    logic [K-1:0]      prev_le;
    logic [CW-1:0]     occ;
    logic [NW-1:0]     n_cnt;
    logic              in_fire;
    logic              out_fire;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            (state == ACCUM): if (in_fire && in_last) state_nxt = HOLD;
            (state == HOLD):  if (out_fire) state_nxt = ACCUM;
            default:          state_nxt = ACCUM;
        endcase
    end

    // le is a prefix mask because slots stay sorted; using <= keeps ties stable
    always_comb begin
        le = '0;
        for (int i = 0; i < K; i++)
            le[i] = (i < int'(occ)) && (slot_d[i] <= in_distance);
    end

    always_comb begin
        prev_le = (le << 1) | K'(1);
        sh_d[0] = in_distance;
        sh_t[0] = in_type;
        for (int i = 1; i < K; i++) begin
            sh_d[i] = slot_d[i-1];
            sh_t[i] = slot_t[i-1];
        end
        for (int i = 0; i < K; i++) begin
            nxt_d[i] = slot_d[i];
            nxt_t[i] = slot_t[i];
            if (!le[i]) begin
                if (prev_le[i]) begin
                    nxt_d[i] = in_distance;
                    nxt_t[i] = in_type;
                end else begin
                    nxt_d[i] = sh_d[i];
                    nxt_t[i] = sh_t[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || out_fire) begin
            for (int i = 0; i < K; i++) begin
                slot_d[i] <= '1;
                slot_t[i] <= '0;
            end
            occ   <= '0;
            n_cnt <= '0;
        end else if (in_fire) begin
            for (int i = 0; i < K; i++) begin
                slot_d[i] <= nxt_d[i];
                slot_t[i] <= nxt_t[i];
            end
            if (occ != CW'(K))
                occ <= occ + 1'b1;
            if (n_cnt != NW'(MAX_N + 1))
                n_cnt <= n_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < K; i++) begin : g_out
        assign out_distance[i*W +: W]        = slot_d[i];
        assign out_type[i*TYPE_W +: TYPE_W]  = slot_t[i];
    end

    assign out_count    = occ;
    assign out_overflow = (n_cnt > NW'(MAX_N));

endmodule

// File: tb/tb_knn_topk_stream_sort.sv
// Directed bench for knn_topk_stream_sort with a result scoreboard.
module tb_knn_topk_stream_sort;

    localparam int W     = 16;
    localparam int TW    = 4;
    localparam int K     = 4;
    localparam int MAX_N = 8;
    localparam int CW    = $clog2(K + 1);
    localparam int RW    = K*W + K*TW + CW + 1;

    typedef struct packed {
        logic [K*W-1:0]  d;
        logic [K*TW-1:0] t;
        logic [CW-1:0]   c;
        logic            o;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, in_last;
    logic [W-1:0] in_distance;
    logic [TW-1:0] in_type;
    logic out_valid, out_ready, out_overflow;
    logic [K*W-1:0] out_distance;
    logic [K*TW-1:0] out_type;
    logic [CW-1:0] out_count;

    int checks = 0;
    int failures = 0;
    res_t exp_q[$];
    logic [W-1:0] fd[$];
    logic [TW-1:0] ft[$];

    always #5 clk = ~clk;

    knn_topk_stream_sort #(.W(W), .TYPE_W(TW), .K(K), .MAX_N(MAX_N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_distance(in_distance), .in_type(in_type), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_distance(out_distance), .out_type(out_type),
        .out_count(out_count), .out_overflow(out_overflow)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: repeated earliest-minimum selection over the whole frame
    function automatic res_t model();
        res_t r;
        bit taken [64];
        int n = fd.size();
        for (int j = 0; j < 64; j++) taken[j] = 1'b0;
        for (int s = 0; s < K; s++) begin
            int best = -1;
            for (int j = 0; j < n; j++)
                if (!taken[j] && (best < 0 || fd[j] < fd[best])) best = j;
            if (best >= 0) begin
                taken[best] = 1'b1;
                r.d[s*W +: W] = fd[best];
                r.t[s*TW +: TW] = ft[best];
            end else begin
                r.d[s*W +: W] = '1;
                r.t[s*TW +: TW] = '0;
            end
        end
        r.c = CW'(n < K ? n : K);
        r.o = (n > MAX_N);
        return r;
    endfunction

    task automatic compare_pop();
        res_t e;
        chk("sb_nonempty", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_distance", 128'(out_distance), 128'(e.d));
            chk("sb_type", 128'(out_type), 128'(e.t));
            chk("sb_count", 128'(out_count), 128'(e.c));
            chk("sb_overflow", 128'(out_overflow), 128'(e.o));
        end
    endtask

    task automatic step();
        if (out_valid === 1'b1 && out_ready === 1'b1) compare_pop();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_frame();
        fd.delete();
        ft.delete();
    endtask

    task automatic add(input int d, input int t);
        fd.push_back(W'(d));
        ft.push_back(TW'(t));
    endtask

    task automatic send(input bit gaps, input bit with_last, output int waits);
        int n = fd.size();
        waits = 0;
        if (with_last) exp_q.push_back(model());
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) step();
            end
            in_valid = 1'b0;
            while (!in_ready && waits < 20) begin
                step();
                waits++;
            end
            if (waits >= 20) chk("in_ready_timeout", 128'(in_ready), 128'(1));
            in_valid = 1'b1;
            in_distance = fd[i];
            in_type = ft[i];
            in_last = with_last && (i == n - 1);
            step();
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        if (with_last) chk("latency", 128'(out_valid), 128'(1));
    endtask

    task automatic collect(input int hold);
        logic [RW-1:0] snap;
        int t = 0;
        while (out_valid !== 1'b1 && t < 20) begin
            step();
            t++;
        end
        chk("out_valid_wait", 128'(out_valid), 128'(1));
        snap = {out_distance, out_type, out_count, out_overflow};
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_stable",
                128'({out_valid, in_ready, out_distance, out_type,
                      out_count, out_overflow}),
                128'({2'b10, snap}));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("release", 128'({in_ready, out_valid}), 128'(2'b10));
    endtask

    initial begin
        int w;
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_distance = '0;
        in_type = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("reset_hs", 128'({in_ready, out_valid}), 128'(2'b10));
        chk("reset_cnt", 128'({out_count, out_overflow}), 128'(0));
        chk("reset_dist", 128'(out_distance), 128'({K*W{1'b1}}));
        chk("reset_type", 128'(out_type), 128'(0));

        clear_frame();
        add(9, 1); add(3, 2); add(7, 3); add(3, 4); add(1, 5); add(8, 6);
        send(1'b0, 1'b1, w);
        chk("basic_dist", 128'(out_distance), 128'({16'd7, 16'd3, 16'd3, 16'd1}));
        chk("basic_type", 128'(out_type), 128'({4'd3, 4'd4, 4'd2, 4'd5}));
        collect(0);

        clear_frame();
        add(5, 1); add(2, 2);
        send(1'b0, 1'b1, w);
        chk("short_dist", 128'(out_distance),
            128'({16'hFFFF, 16'hFFFF, 16'd5, 16'd2}));
        chk("short_type", 128'(out_type), 128'({4'd0, 4'd0, 4'd1, 4'd2}));
        collect(0);

        clear_frame();
        for (int i = 0; i < 6; i++)
            add($urandom_range(0, 300), $urandom_range(0, 15));
        send(1'b0, 1'b1, w);
        collect(5);
        clear_frame();
        add(100, 9); add(50, 8);
        send(1'b0, 1'b1, w);
        collect(0);

        clear_frame();
        for (int i = 1; i <= 5; i++) add(4, i);
        send(1'b1, 1'b1, w);
        chk("ties_type", 128'(out_type), 128'({4'd4, 4'd3, 4'd2, 4'd1}));
        collect(0);
        clear_frame();
        add(0, 7);
        send(1'b1, 1'b1, w);
        chk("single", 128'({out_count, out_distance[W-1:0], out_type[TW-1:0]}),
            128'({3'd1, 16'd0, 4'd7}));
        collect(0);

        clear_frame();
        for (int i = 0; i < 10; i++)
            add($urandom_range(0, 50), $urandom_range(0, 15));
        send(1'b0, 1'b1, w);
        chk("ovf_set", 128'(out_overflow), 128'(1));
        collect(0);
        clear_frame();
        for (int i = 0; i < 8; i++)
            add($urandom_range(0, 50), $urandom_range(0, 15));
        send(1'b1, 1'b1, w);
        chk("ovf_clear", 128'(out_overflow), 128'(0));
        collect(0);

        out_ready = 1'b1;
        clear_frame();
        for (int i = 0; i < 4; i++) add($urandom_range(0, 1000), i + 1);
        send(1'b0, 1'b1, w);
        clear_frame();
        for (int i = 0; i < 3; i++) add($urandom_range(0, 1000), i + 8);
        send(1'b0, 1'b1, w);
        chk("b2b_bubble", 128'(w), 128'(1));
        step();
        step();
        out_ready = 1'b0;
        chk("b2b_idle", 128'({in_ready, out_valid}), 128'(2'b10));

        clear_frame();
        add(30, 1); add(5, 2); add(12, 3);
        send(1'b0, 1'b0, w);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_clear", 128'({out_count, out_distance}),
            128'({3'd0, {K*W{1'b1}}}));
        clear_frame();
        add(20, 1); add(10, 2);
        send(1'b0, 1'b1, w);
        chk("rst_mid_result", 128'({out_count, out_distance}),
            128'({3'd2, 16'hFFFF, 16'hFFFF, 16'd20, 16'd10}));
        collect(0);

        clear_frame();
        add(1, 1); add(2, 2); add(3, 3);
        send(1'b0, 1'b1, w);
        void'(exp_q.pop_back());
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_hold", 128'({out_valid, in_ready, out_count}),
            128'({2'b01, 3'd0}));

        chk("sb_drain", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
